// File: rtl/uart_pkg.sv
// uart_pkg: shared phase encoding and default frame configuration for the UART frame sequencer
package uart_pkg;

    typedef enum logic [2:0] {PH_IDLE, PH_START, PH_DATA, PH_PARITY, PH_STOP} uart_phase_e;

    localparam int   UART_MIN_DATA_BITS = 5;
    localparam int   UART_DEF_DATA_BITS = 8;
    localparam logic UART_DEF_PARITY_EN = 1'b0;
    localparam logic UART_DEF_TWO_STOP  = 1'b0;

endpackage

// File: rtl/uart_cfg_latch.sv
// uart_cfg_latch: saturates the requested data-bit count and captures the frame config at frame start
module uart_cfg_latch import uart_pkg::*; #(
    parameter  int MAX_DATA_BITS = 8,
    localparam int IDX_W         = $clog2(MAX_DATA_BITS)
) (
    input  logic             tx_clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [IDX_W:0]   cfg_data_bits_i,
    input  logic             cfg_parity_en_i,
    input  logic             cfg_two_stop_i,
    output logic [IDX_W:0]   data_bits_o,
    output logic             parity_en_o,
    output logic             two_stop_o
);

    localparam logic [IDX_W:0] MIN_B = (IDX_W+1)'(UART_MIN_DATA_BITS);
    localparam logic [IDX_W:0] MAX_B = (IDX_W+1)'(MAX_DATA_BITS);
    localparam logic [IDX_W:0] DEF_B = (IDX_W+1)'(UART_DEF_DATA_BITS);

    logic [IDX_W:0] data_bits_q, data_bits_d;
    logic           parity_en_q, two_stop_q;

    assign data_bits_d = cfg_data_bits_i < MIN_B ? MIN_B : (cfg_data_bits_i > MAX_B ? MAX_B : cfg_data_bits_i);

    // capture config only when a new frame is accepted; reset restores 8N1
    always_ff @(posedge tx_clk or negedge reset_n) begin
        if (!reset_n) begin
            data_bits_q <= DEF_B;
            parity_en_q <= UART_DEF_PARITY_EN;
            two_stop_q  <= UART_DEF_TWO_STOP;
        end else if (load_i) begin
            data_bits_q <= data_bits_d;
            parity_en_q <= cfg_parity_en_i;
            two_stop_q  <= cfg_two_stop_i;
        end
    end

    assign data_bits_o = data_bits_q;
    assign parity_en_o = parity_en_q;
    assign two_stop_o  = two_stop_q;

endmodule

// File: rtl/uart_frame_bit_counter.sv
// uart_frame_bit_counter: sequences start/data/parity/stop bits of one UART frame per baud tick; UART_FRAME_STATS_EN adds frame/abort counters
module uart_frame_bit_counter import uart_pkg::*; #(
    parameter  int MAX_DATA_BITS = 8,
    localparam int IDX_W         = $clog2(MAX_DATA_BITS)
) (
    input  logic             tx_clk,
    input  logic             reset_n,
    input  logic             baud_tick,
    input  logic             start,
    input  logic             clear_count,
    input  logic [IDX_W:0]   cfg_data_bits,
    input  logic             cfg_parity_en,
    input  logic             cfg_two_stop,
    output logic [2:0]       phase,
    output logic [IDX_W-1:0] bit_idx,
    output logic             busy,
    output logic             count_of,
`ifdef UART_FRAME_STATS_EN
    output logic [15:0]      frame_cnt,
    output logic [7:0]       abort_cnt,
`endif
    output logic             uart_done
);

    uart_phase_e      phase_q, phase_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic             stop_q, stop_d;
    logic [IDX_W:0]   data_bits;
    logic             parity_en, two_stop;
    logic             done_c, load_c;

    // the frame ends on the tick of the final stop bit; an abort in the same cycle suppresses it
    assign done_c = !clear_count && baud_tick && phase_q == PH_STOP && stop_q == two_stop;
    assign load_c = !clear_count && start && (phase_q == PH_IDLE || done_c);

    uart_cfg_latch #(.MAX_DATA_BITS(MAX_DATA_BITS)) u_cfg (
        .tx_clk          (tx_clk),
        .reset_n         (reset_n),
        .load_i          (load_c),
        .cfg_data_bits_i (cfg_data_bits),
        .cfg_parity_en_i (cfg_parity_en),
        .cfg_two_stop_i  (cfg_two_stop),
        .data_bits_o     (data_bits),
        .parity_en_o     (parity_en),
        .two_stop_o      (two_stop)
    );

    // frame state register
    always_ff @(posedge tx_clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q   <= PH_IDLE;
            bit_idx_q <= '0;
            stop_q    <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            bit_idx_q <= bit_idx_d;
            stop_q    <= stop_d;
        end
    end

    // next phase and counters; abort wins over tick and start
    always_comb begin
        phase_d   = phase_q;
        bit_idx_d = bit_idx_q;
        stop_d    = stop_q;
        if (clear_count) begin
            phase_d   = PH_IDLE;
            bit_idx_d = '0;
            stop_d    = 1'b0;
        end else begin
            case (phase_q)
                PH_IDLE: begin
                    if (start) phase_d = PH_START;
                end
                PH_START: begin
                    if (baud_tick) begin
                        phase_d   = PH_DATA;
                        bit_idx_d = '0;
                    end
                end
                PH_DATA: begin
                    if (baud_tick) begin
                        if ({1'b0, bit_idx_q} < data_bits - 1'b1) begin
                            bit_idx_d = bit_idx_q + 1'b1;
                        end else begin
                            phase_d   = parity_en ? PH_PARITY : PH_STOP;
                            bit_idx_d = '0;
                            stop_d    = 1'b0;
                        end
                    end
                end
                PH_PARITY: begin
                    if (baud_tick) begin
                        phase_d = PH_STOP;
                        stop_d  = 1'b0;
                    end
                end
                PH_STOP: begin
                    if (done_c) begin
                        phase_d = start ? PH_START : PH_IDLE;
                        stop_d  = 1'b0;
                    end else if (baud_tick) begin
                        stop_d = 1'b1;
                    end
                end
                default: phase_d = PH_IDLE;
            endcase
        end
    end

    assign phase     = phase_q;
    assign bit_idx   = bit_idx_q;
    assign busy      = phase_q != PH_IDLE;
    assign count_of  = done_c;
    assign uart_done = done_c;

`ifdef UART_FRAME_STATS_EN
    logic [15:0] frame_cnt_q;
    logic [7:0]  abort_cnt_q;

    // completed frames wrap; aborts of an active frame saturate
    always_ff @(posedge tx_clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_q <= '0;
            abort_cnt_q <= '0;
        end else begin
            if (done_c) frame_cnt_q <= frame_cnt_q + 1'b1;
            if (clear_count && busy && abort_cnt_q != 8'hFF) abort_cnt_q <= abort_cnt_q + 1'b1;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign abort_cnt = abort_cnt_q;
`endif

endmodule

// File: tb/tb_uart_frame_bit_counter.sv
// tb_uart_frame_bit_counter: scoreboard bench for the UART frame sequencer
module tb_uart_frame_bit_counter;

    localparam int MAXB  = 8;
    localparam int IDX_W = $clog2(MAXB);

    typedef struct {
        logic [2:0]       ph;
        logic [IDX_W-1:0] idx;
        logic             done;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             baud_tick = 1'b0;
    logic             start = 1'b0;
    logic             clear_count = 1'b0;
    logic [IDX_W:0]   cfg_data_bits = '0;
    logic             cfg_parity_en = 1'b0;
    logic             cfg_two_stop = 1'b0;
    logic [2:0]       phase;
    logic [IDX_W-1:0] bit_idx;
    logic             busy, count_of, uart_done;
`ifdef UART_FRAME_STATS_EN
    logic [15:0]      frame_cnt;
    logic [7:0]       abort_cnt;
    int               frames_exp = 0;
    int               aborts_exp = 0;
`endif

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    uart_frame_bit_counter #(.MAX_DATA_BITS(MAXB)) dut (
        .tx_clk        (clk),
        .reset_n       (reset_n),
        .baud_tick     (baud_tick),
        .start         (start),
        .clear_count   (clear_count),
        .cfg_data_bits (cfg_data_bits),
        .cfg_parity_en (cfg_parity_en),
        .cfg_two_stop  (cfg_two_stop),
        .phase         (phase),
        .bit_idx       (bit_idx),
        .busy          (busy),
        .count_of      (count_of),
`ifdef UART_FRAME_STATS_EN
        .frame_cnt     (frame_cnt),
        .abort_cnt     (abort_cnt),
`endif
        .uart_done     (uart_done)
    );

    task automatic push_frame(input int bits, input bit par, input bit two);
        int eff;
        eff = bits < 5 ? 5 : (bits > MAXB ? MAXB : bits);
        exp_q.push_back('{3'd1, '0, 1'b0});
        for (int k = 0; k < eff; k++) exp_q.push_back('{3'd2, IDX_W'(k), 1'b0});
        if (par) exp_q.push_back('{3'd3, '0, 1'b0});
        exp_q.push_back('{3'd4, '0, !two});
        if (two) exp_q.push_back('{3'd4, '0, 1'b1});
    endtask

    task automatic do_start(input int bits, input bit par, input bit two);
        @(negedge clk);
        cfg_data_bits = (IDX_W+1)'(bits);
        cfg_parity_en = par;
        cfg_two_stop  = two;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cfg_data_bits = (IDX_W+1)'($urandom_range(0, 15));
        cfg_parity_en = ~par;
        cfg_two_stop  = ~two;
        n_tests++;
        if (phase !== 3'd1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL start_accept: phase=%0d busy=%b, expected phase=1 busy=1", phase, busy);
        end
        push_frame(bits, par, two);
    endtask

    task automatic play(input int n, input bit b2b);
        exp_t e;
        for (int t = 0; t < n && exp_q.size() > 0; t++) begin
            repeat (3) begin
                @(negedge clk);
                n_tests++;
                if (phase !== exp_q[0].ph || count_of !== 1'b0) begin
                    n_fail++;
                    $display("FAIL hold_no_tick: phase=%0d count_of=%b, expected phase=%0d count_of=0", phase, count_of, exp_q[0].ph);
                end
            end
            baud_tick = 1'b1;
            start = b2b && exp_q.size() == 1;
            #1;
            e = exp_q.pop_front();
            n_tests++;
            if (phase !== e.ph || bit_idx !== e.idx || count_of !== e.done || uart_done !== e.done) begin
                n_fail++;
                $display("FAIL tick_seq: phase=%0d idx=%0d count_of=%b uart_done=%b, expected phase=%0d idx=%0d done=%b",
                         phase, bit_idx, count_of, uart_done, e.ph, e.idx, e.done);
            end
`ifdef UART_FRAME_STATS_EN
            if (e.done) frames_exp++;
`endif
            @(negedge clk);
            baud_tick = 1'b0;
            start = 1'b0;
        end
    endtask

    task automatic check_idle(input string name);
        n_tests++;
        if (phase !== 3'd0 || bit_idx !== '0 || busy !== 1'b0 || count_of !== 1'b0 || uart_done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: phase=%0d idx=%0d busy=%b count_of=%b uart_done=%b, expected all 0", name, phase, bit_idx, busy, count_of, uart_done);
        end
`ifdef UART_FRAME_STATS_EN
        n_tests++;
        if (frame_cnt !== 16'(frames_exp) || abort_cnt !== 8'(aborts_exp)) begin
            n_fail++;
            $display("FAIL %s_stats: frame_cnt=%0d abort_cnt=%0d, expected %0d %0d", name, frame_cnt, abort_cnt, frames_exp, aborts_exp);
        end
`endif
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        check_idle("reset");
        reset_n = 1'b1;
        @(negedge clk);
        check_idle("reset_release");
    endtask

    task automatic test_8n1;
        do_start(8, 0, 0);
        play(100, 0);
        check_idle("8n1_end");
    endtask

    task automatic test_5e2;
        do_start(5, 1, 1);
        play(100, 0);
        check_idle("5e2_end");
    endtask

    task automatic test_back_to_back;
        do_start(8, 0, 0);
        cfg_data_bits = 4'd5;
        cfg_parity_en = 1'b1;
        cfg_two_stop  = 1'b1;
        play(100, 1);
        n_tests++;
        if (phase !== 3'd1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_direct_start: phase=%0d busy=%b, expected phase=1 busy=1", phase, busy);
        end
        push_frame(5, 1, 1);
        play(100, 0);
        check_idle("b2b_end");
    endtask

    task automatic test_clear;
        do_start(8, 0, 0);
        play(3, 0);
        repeat (3) @(negedge clk);
        baud_tick = 1'b1;
        clear_count = 1'b1;
        start = 1'b1;
        #1;
        n_tests++;
        if (count_of !== 1'b0 || uart_done !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_no_done: count_of=%b uart_done=%b, expected 0 0", count_of, uart_done);
        end
`ifdef UART_FRAME_STATS_EN
        aborts_exp++;
`endif
        @(negedge clk);
        baud_tick = 1'b0;
        clear_count = 1'b0;
        start = 1'b0;
        exp_q.delete();
        check_idle("clear_idle");
        @(negedge clk);
        check_idle("clear_start_dropped");
    endtask

    task automatic test_async_reset;
        do_start(8, 0, 0);
        play(4, 0);
        #2 reset_n = 1'b0;
        #1;
        exp_q.delete();
`ifdef UART_FRAME_STATS_EN
        frames_exp = 0;
        aborts_exp = 0;
`endif
        check_idle("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        do_start(8, 0, 0);
        play(100, 0);
        check_idle("after_reset_frame");
    endtask

    task automatic test_saturation;
        do_start(3, 0, 0);
        play(100, 0);
        check_idle("sat_low_end");
        do_start(15, 0, 0);
        play(100, 0);
        check_idle("sat_high_end");
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_5e2();
        test_back_to_back();
        test_clear();
        test_async_reset();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
